// File: rtl/multi_digit_tick_counter.sv
// Prescaled multi-digit hex/BCD up/down counter with load, clear and terminal count.
// Define MULTI_DIGIT_TICK_COUNTER_SATURATE_EN to saturate at the limits instead of wrapping.
module multi_digit_tick_counter #(
  parameter int DIGITS   = 4,
  parameter int TICK_DIV = 25_000_000,
  parameter int BCD      = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                up,
  input  logic                clr,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_val,
  output logic [4*DIGITS-1:0] count,
  output logic                tick,
  output logic                tc
);

  localparam int W  = 4 * DIGITS;
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PLAST = PW'(TICK_DIV - 1);
  localparam logic [3:0] DMAX = (BCD != 0) ? 4'd9 : 4'd15;

  logic [PW-1:0] presc_q, presc_d;
  logic [W-1:0]  count_q, count_d;
  logic          tick_q, tick_d;
  logic          tc_q, tc_d;

  logic          step;
  logic          wrap;
  logic [W-1:0]  inc_v, dec_v, ld_v;
  logic          inc_co, dec_bo;

  assign step = en && (presc_q == PLAST);

  // Ripple carry/borrow; the carry out of the top digit is the wrap flag.
  always_comb begin
    inc_v  = '0;
    dec_v  = '0;
    ld_v   = '0;
    inc_co = 1'b1;
    dec_bo = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if (!inc_co) begin
        inc_v[4*k +: 4] = count_q[4*k +: 4];
      end else if (count_q[4*k +: 4] >= DMAX) begin
        inc_v[4*k +: 4] = 4'd0;
      end else begin
        inc_v[4*k +: 4] = count_q[4*k +: 4] + 4'd1;
        inc_co = 1'b0;
      end

      if (!dec_bo) begin
        dec_v[4*k +: 4] = count_q[4*k +: 4];
      end else if (count_q[4*k +: 4] == 4'd0) begin
        dec_v[4*k +: 4] = DMAX;
      end else begin
        dec_v[4*k +: 4] = count_q[4*k +: 4] - 4'd1;
        dec_bo = 1'b0;
      end

      if ((BCD != 0) && (load_val[4*k +: 4] > 4'd9)) begin
        ld_v[4*k +: 4] = 4'd9;
      end else begin
        ld_v[4*k +: 4] = load_val[4*k +: 4];
      end
    end
  end

  assign wrap = up ? inc_co : dec_bo;

  always_comb begin
    presc_d = presc_q;
    count_d = count_q;
    tick_d  = 1'b0;
    tc_d    = 1'b0;
    if (clr) begin
      count_d = '0;
      presc_d = '0;
    end else if (load) begin
      count_d = ld_v;
      presc_d = '0;
    end else begin
      if (en) begin
        presc_d = step ? '0 : presc_q + PW'(1);
      end
      if (step) begin
        tick_d = 1'b1;
        tc_d   = wrap;
`ifdef MULTI_DIGIT_TICK_COUNTER_SATURATE_EN
        if (!wrap) begin
          count_d = up ? inc_v : dec_v;
        end
`else
        count_d = up ? inc_v : dec_v;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      count_q <= '0;
      tick_q  <= 1'b0;
      tc_q    <= 1'b0;
    end else begin
      presc_q <= presc_d;
      count_q <= count_d;
      tick_q  <= tick_d;
      tc_q    <= tc_d;
    end
  end

  assign count = count_q;
  assign tick  = tick_q;
  assign tc    = tc_q;

endmodule

// File: tb/tb_multi_digit_tick_counter.sv
// Bench for multi_digit_tick_counter: hex and BCD instances against a value-level model.
// Honours MULTI_DIGIT_TICK_COUNTER_SATURATE_EN for expected boundary behaviour.
module tb_multi_digit_tick_counter;

  localparam int TD = 4;
`ifdef MULTI_DIGIT_TICK_COUNTER_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en, up, clr, load;
  logic [7:0] load_val;
  logic [7:0] cnt_h, cnt_b;
  logic       tick_h, tick_b, tc_h, tc_b;

  int n_tests = 0;
  int n_fail  = 0;

  // model: counts as plain integers
  int mh, mb, ph;
  bit etick, etc_h, etc_b;

  always #5 clk = ~clk;

  multi_digit_tick_counter #(.DIGITS(2), .TICK_DIV(TD), .BCD(0)) u_hex (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .clr(clr), .load(load),
    .load_val(load_val), .count(cnt_h), .tick(tick_h), .tc(tc_h)
  );

  multi_digit_tick_counter #(.DIGITS(2), .TICK_DIV(TD), .BCD(1)) u_bcd (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .clr(clr), .load(load),
    .load_val(load_val), .count(cnt_b), .tick(tick_b), .tc(tc_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int clamp_bcd(input logic [7:0] v);
    int hi, lo;
    hi = (v[7:4] > 4'd9) ? 9 : int'(v[7:4]);
    lo = (v[3:0] > 4'd9) ? 9 : int'(v[3:0]);
    return 10 * hi + lo;
  endfunction

  function automatic logic [7:0] to_bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  task automatic model_reset();
    mh = 0; mb = 0; ph = 0;
    etick = 0; etc_h = 0; etc_b = 0;
  endtask

  task automatic model_step();
    bit stp;
    if (clr) begin
      model_reset();
    end else if (load) begin
      mh = int'(load_val);
      mb = clamp_bcd(load_val);
      ph = 0;
      etick = 0; etc_h = 0; etc_b = 0;
    end else begin
      stp = en && (ph == TD - 1);
      if (en) ph = (ph + 1) % TD;
      etick = stp; etc_h = 0; etc_b = 0;
      if (stp) begin
        if (up) begin
          if (mh == 255) begin etc_h = 1; mh = SAT ? 255 : 0; end
          else mh = mh + 1;
          if (mb == 99) begin etc_b = 1; mb = SAT ? 99 : 0; end
          else mb = mb + 1;
        end else begin
          if (mh == 0) begin etc_h = 1; mh = SAT ? 0 : 255; end
          else mh = mh - 1;
          if (mb == 0) begin etc_b = 1; mb = SAT ? 0 : 99; end
          else mb = mb - 1;
        end
      end
    end
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    chk("cnt_hex", 32'(cnt_h), 32'(mh));
    chk("cnt_bcd", 32'(cnt_b), 32'(to_bcd(mb)));
    chk("tick_hex", 32'(tick_h), 32'(etick));
    chk("tick_bcd", 32'(tick_b), 32'(etick));
    chk("tc_hex", 32'(tc_h), 32'(etc_h));
    chk("tc_bcd", 32'(tc_b), 32'(etc_b));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic do_load(input logic [7:0] v);
    load = 1'b1; load_val = v;
    cyc();
    load = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; up = 1'b1; clr = 1'b0; load = 1'b0;
    load_val = 8'h00;
    model_reset();
    #3;
    chk("rst_cnt_hex", 32'(cnt_h), 0);
    chk("rst_cnt_bcd", 32'(cnt_b), 0);
    chk("rst_tick", 32'(tick_h), 0);
    chk("rst_tc", 32'(tc_h), 0);
    #4;
    rst_n = 1'b1; en = 1'b1; up = 1'b1;

    // first tick four cycles after release
    run(3);
    chk("pre_tick", 32'(tick_h), 0);
    cyc();
    chk("first_tick", 32'(tick_h), 1);
    chk("first_cnt", 32'(cnt_h), 32'h01);

    // hex wrap from FE
    do_load(8'hFE);
    chk("ld_hex", 32'(cnt_h), 32'hFE);
    chk("ld_bcd_clamp", 32'(cnt_b), 32'h99);
    run(TD);
    chk("hex_ff", 32'(cnt_h), 32'hFF);
    chk("hex_ff_tc", 32'(tc_h), 0);
    run(TD);
    chk("hex_wrap", 32'(cnt_h), SAT ? 32'hFF : 32'h00);
    chk("hex_wrap_tc", 32'(tc_h), 1);

    // BCD carry and wrap
    do_load(8'h09);
    run(TD);
    chk("bcd_carry", 32'(cnt_b), 32'h10);
    do_load(8'h99);
    run(TD);
    chk("bcd_wrap", 32'(cnt_b), SAT ? 32'h99 : 32'h00);
    chk("bcd_wrap_tc", 32'(tc_b), 1);
    do_load(8'h0F);
    chk("bcd_ld_0f", 32'(cnt_b), 32'h09);
    chk("hex_ld_0f", 32'(cnt_h), 32'h0F);
    up = 1'b0;
    do_load(8'h00);
    run(TD);
    chk("bcd_down", 32'(cnt_b), SAT ? 32'h00 : 32'h99);
    chk("bcd_down_tc", 32'(tc_b), 1);
    chk("hex_down", 32'(cnt_h), SAT ? 32'h00 : 32'hFF);
    chk("hex_down_tc", 32'(tc_h), 1);
    up = 1'b1;

    // pause mid-period, resume finishes remaining cycles only
    run(2);
    en = 1'b0;
    run(10);
    en = 1'b1;
    cyc();
    chk("resume_wait", 32'(tick_h), 0);
    cyc();
    chk("resume_tick", 32'(tick_h), 1);

    // clr+load in the step cycle
    run(TD - 1);
    clr = 1'b1; load = 1'b1; load_val = 8'h55;
    cyc();
    clr = 1'b0; load = 1'b0;
    chk("clr_ld_cnt", 32'(cnt_h), 0);
    chk("clr_ld_tick", 32'(tick_h), 0);
    chk("clr_ld_tc", 32'(tc_h), 0);

    // async reset mid-period
    do_load(8'h37);
    run(2);
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst_hex", 32'(cnt_h), 0);
    chk("arst_bcd", 32'(cnt_b), 0);
    chk("arst_tick", 32'(tick_h), 0);
    chk("arst_tc", 32'(tc_h), 0);
    #2;
    rst_n = 1'b1;
    run(TD);
    chk("arst_first", 32'(cnt_h), 32'h01);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      en       = ($urandom_range(0, 9) != 0);
      up       = 1'($urandom_range(0, 1));
      clr      = ($urandom_range(0, 49) == 0);
      load     = ($urandom_range(0, 19) == 0);
      load_val = 8'($urandom);
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/multi_digit_tick_counter.md
Name: multi_digit_tick_counter

Overview:
- Parametrised successor to the board's free-running half-second hex counter.
- Built-in prescaler generates a step tick from clk every TICK_DIV cycles.
- Counter is DIGITS nibbles wide and runs in hex or BCD mode, counting up or down, with enable, synchronous clear, parallel load and a terminal-count pulse.
- Output nibbles feed the existing per-digit seven-segment decoders directly.

Parameters:
- DIGITS, 4: number of 4-bit digits. Counter width W = 4*DIGITS. Legal range 1..8.
- TICK_DIV, 25_000_000: tick period in clk cycles. Legal range >= 1. Prescaler width = max(1, clog2(TICK_DIV)).
- BCD, 0: 0 = binary hex counter, digit range 0..F. 1 = decimal counter, each digit 0..9.

Ports:
- clk, input, 1: single clock, all state is on its rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- en, input, 1: 1 = prescaler runs and ticks step the counter. 0 = everything holds.
- up, input, 1: 1 = increment on tick, 0 = decrement. Sampled in the step cycle.
- clr, input, 1: synchronous clear of count and prescaler.
- load, input, 1: synchronous parallel load.
- load_val, input, W: value loaded when load=1.
- count, output, W: current count. Digit k is bits [4k+3:4k].
- tick, output, 1: one-cycle pulse, asserted in the cycle count shows a stepped value.
- tc, output, 1: one-cycle terminal-count pulse on wrap (or saturate attempt).

Behaviour:
- Reset (rst_n=0, asynchronous):
  - count=0, prescaler=0, tick=0, tc=0.
  - Takes effect immediately, also mid-period. Release restarts a full TICK_DIV period.
- Prescaler:
  - When en=1, presc increments each cycle.
  - When presc==TICK_DIV-1 and en=1, step_pre=1 and presc goes to 0 at the next edge.
  - Period is exactly TICK_DIV cycles. TICK_DIV=1 gives step_pre=1 every enabled cycle.
  - en=0: presc holds and step_pre=0.
- Priority per edge, highest first:
  - clr: count<=0, presc<=0, tick<=0, tc<=0.
  - load: count<=load_val (BCD=1: any digit >9 is stored as 9), presc<=0, tick<=0, tc<=0. Loaded value appears the cycle after load.
  - step_pre: count steps, tick<=1.
  - Otherwise: count holds, tick<=0, tc<=0.
- Step arithmetic:
  - Ripple carry/borrow digit by digit.
  - BCD=1: digit 9+1 gives 0 with carry; digit 0-1 gives 9 with borrow.
  - BCD=0: plain W-bit +/-1.
- Wrap:
  - Up from MAX (all F, or all 9 when BCD) goes to 0, with tc<=1.
  - Down from 0 goes to MAX, with tc<=1.
  - tc is coincident with tick and with the wrapped count value.
- Latency:
  - count, tick and tc are registered.
  - New count is visible one cycle after the step_pre cycle, together with tick=1.
- Simultaneous events:
  - clr with load: clr wins.
  - load with step_pre: the load wins and the step is lost.
  - up changing mid-period: only the value in the step_pre cycle matters.
  - en dropping in the step_pre cycle: no step; presc holds at TICK_DIV-1.

Optional Feature:
- Macro MULTI_DIGIT_TICK_COUNTER_SATURATE_EN.
- Defined:
  - Counter saturates instead of wrapping. Up at MAX holds MAX; down at 0 holds 0.
  - tc pulses (with tick) on every step attempted at the boundary.
- Undefined: wrap behaviour as described above.
- All other behaviour is identical in both builds.

Test Plan:
1. DIGITS=2, TICK_DIV=4, BCD=0. Release reset, en=1, up=1 -> tick every 4 cycles; count 00,01,02... First tick is 4 cycles after release.
2. Same config, load 8'hFE, then two ticks -> count FF, then 00 with tc=1 on the second tick only.
3. BCD=1, DIGITS=2. Load 8'h09, step up -> 10. Step up from 99 -> 00 with tc=1. Load 8'h0F -> count reads 09. Down from 00 -> 99 with tc=1.
4. en=0 for 10 cycles mid-period -> no tick, count holds. Re-enable -> tick arrives after the remaining period cycles only.
5. clr and load asserted together with step_pre -> count=00, tick=0, tc=0. Assert rst_n=0 asynchronously mid-period -> all outputs 0 immediately.
6. Saturate build, BCD=0, DIGITS=2. Count up from FE -> FF, then stays FF with tc=1 on each further tick. Down from 00 -> stays 00 with tc=1.
